gates_sweep_ctrl: RTL and testbench
===================================

Name: gates_sweep_ctrl

Overview:
Sequencer that drives a 3-input clocked logic block (inputs A, B, C, output Z) through all 8 input combinations and captures Z for each. It builds the 8-entry truth table and compares it against an expected table. The result is a pass/fail flag and an error count. It sits beside the gate block in lab/self-test builds and replaces hand-written stimulus sequences.

Parameters:
SETTLE_CYCLES, 1, number of extra cycles each vector is held before Z is sampled (range 0..15; 1 matches a DUT with one register stage)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a sweep; accepted only in IDLE
abort  input  1  cancel the sweep in progress; synchronous
expected  input  8  expected truth table, bit k = Z for {A,B,C}=k; sampled on the start-accept edge
Z  input  1  output of the gate block
A  output  1  gate input, MSB of vector index
B  output  1  gate input
C  output  1  gate input, LSB of vector index
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
truth  output  8  captured Z values, bit k = vector k
pass  output  1  truth == expected; valid from done, held until the next start
err_count  output  4  number of mismatching vectors (0..8)
first_err_idx  output  3  index of the lowest mismatching vector; 0 if there is none

Behaviour:
- One clock. Reset is synchronous and active-high; ports are clk and reset. All outputs are registered.
- Reset values: A=B=C=0, busy=0, done=0, truth=0, pass=0, err_count=0, first_err_idx=0, state=IDLE.
- States: IDLE, DRIVE, SETTLE, CAPTURE, DONE.
- IDLE, start=1: latch expected into exp_r; idx=0; clear truth, err_count, first_err_idx and pass; busy=1; go to DRIVE.
- DRIVE: {A,B,C}=idx, visible from the next cycle; load hold counter = SETTLE_CYCLES; go to SETTLE. If SETTLE_CYCLES=0, go directly to CAPTURE.
- SETTLE: decrement the counter; at 0 go to CAPTURE.
- CAPTURE: Z is sampled exactly SETTLE_CYCLES+1 rising edges after {A,B,C} changes.
  - truth[idx] <= Z.
  - On mismatch with exp_r[idx]: err_count += 1, saturating at 8. If this is the first error, first_err_idx <= idx.
  - If idx==7 go to DONE; otherwise idx += 1 and go to DRIVE.
- Per-vector period is exactly SETTLE_CYCLES+2 cycles (DRIVE + SETTLE_CYCLES + CAPTURE). Total busy time = 8*(SETTLE_CYCLES+2) cycles.
- DONE (one cycle): done=1, busy=0, A=B=C=0, pass <= (err_count==0 including the final capture). Then go to IDLE.
- start while busy, or in the DONE cycle: ignored. It does not restart the sweep or relatch expected.
- start held high continuously: a new sweep is accepted on the first IDLE cycle after DONE.
- abort in any non-IDLE state: next edge returns to IDLE with busy=0 and A=B=C=0. No done pulse. truth, err_count, first_err_idx and pass are cleared to 0.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, no sweep starts.
- reset mid-sweep: all outputs return to reset values at that edge. No done pulse. Reset overrides abort and start.
- Changes to expected during a sweep have no effect.
- Z is treated as 2-state. X handling is the bench's responsibility.

Test Plan:
1. Majority DUT (1 register stage), SETTLE_CYCLES=1, expected=8'hE8, start pulse -> A,B,C step 000..111 with each vector held 3 cycles; done 24 cycles after the start-accept edge; truth=E8, pass=1, err_count=0.
2. Same DUT, expected=8'hE9 -> truth=E8, pass=0, err_count=1, first_err_idx=0; expected=8'h68 -> err_count=1, first_err_idx=7.
3. Combinational AND3 model, SETTLE_CYCLES=0, expected=8'h80 -> each vector held 2 cycles; done at cycle 16; truth=80, pass=1.
4. Extra start pulses at cycles 3 and 10 of a sweep -> vector sequence and timing unchanged; exactly one done pulse.
5. reset at cycle 5 of a sweep -> all outputs at reset values after that edge; no done. A following start produces a clean full sweep with correct results.
6. abort at cycle 7 -> busy=0 and truth=0 the next cycle; no done. abort+start in the same IDLE cycle -> busy stays 0.

Source files
------------

// File: rtl/gates_sweep_ctrl.sv
// rtl/gates_sweep_ctrl.sv - steps a 3-input gate through all 8 vectors and checks its truth table
// Each vector is held SETTLE_CYCLES+2 cycles; Z is sampled SETTLE_CYCLES+1 edges after {A,B,C} changes.
module gates_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       Z,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [7:0] r_exp;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_truth;
    logic       r_pass;
    logic [3:0] r_err_count;
    logic [2:0] r_first_err_idx;

    state_t     w_state;
    logic [2:0] w_idx;
    logic [3:0] w_cnt;
    logic [7:0] w_exp;
    logic [2:0] w_abc;
    logic       w_busy;
    logic       w_done;
    logic [7:0] w_truth;
    logic       w_pass;
    logic [3:0] w_err_count;
    logic [2:0] w_first_err_idx;
    logic       w_mismatch;

    assign w_mismatch = (Z != r_exp[r_idx]);

    always_comb begin
        w_state         = r_state;
        w_idx           = r_idx;
        w_cnt           = r_cnt;
        w_exp           = r_exp;
        w_abc           = r_abc;
        w_busy          = r_busy;
        w_done          = 1'b0;
        w_truth         = r_truth;
        w_pass          = r_pass;
        w_err_count     = r_err_count;
        w_first_err_idx = r_first_err_idx;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_exp           = expected;
                    w_idx           = 3'd0;
                    w_truth         = 8'd0;
                    w_err_count     = 4'd0;
                    w_first_err_idx = 3'd0;
                    w_pass          = 1'b0;
                    w_busy          = 1'b1;
                    w_state         = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_abc = r_idx;
                w_cnt = LP_SETTLE;
                if (LP_SETTLE == 4'd0) begin
                    w_state = S_CAPTURE;
                end else begin
                    w_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_truth[r_idx] = Z;
                if (w_mismatch) begin
                    if (r_err_count != 4'd8) begin
                        w_err_count = r_err_count + 4'd1;
                    end
                    // No earlier mismatch recorded means this is the lowest failing index.
                    if (r_err_count == 4'd0) begin
                        w_first_err_idx = r_idx;
                    end
                end
                if (r_idx == 3'd7) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_abc   = 3'd0;
                    w_pass  = (w_err_count == 4'd0);
                end else begin
                    w_idx   = r_idx + 3'd1;
                    w_state = S_DRIVE;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_state         = S_IDLE;
            w_busy          = 1'b0;
            w_done          = 1'b0;
            w_abc           = 3'd0;
            w_truth         = 8'd0;
            w_err_count     = 4'd0;
            w_first_err_idx = 3'd0;
            w_pass          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= 3'd0;
            r_cnt           <= 4'd0;
            r_exp           <= 8'd0;
            r_abc           <= 3'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_truth         <= 8'd0;
            r_pass          <= 1'b0;
            r_err_count     <= 4'd0;
            r_first_err_idx <= 3'd0;
        end else begin
            r_state         <= w_state;
            r_idx           <= w_idx;
            r_cnt           <= w_cnt;
            r_exp           <= w_exp;
            r_abc           <= w_abc;
            r_busy          <= w_busy;
            r_done          <= w_done;
            r_truth         <= w_truth;
            r_pass          <= w_pass;
            r_err_count     <= w_err_count;
            r_first_err_idx <= w_first_err_idx;
        end
    end

    assign A             = r_abc[2];
    assign B             = r_abc[1];
    assign C             = r_abc[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign truth         = r_truth;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// tb/tb_gates_sweep_ctrl.sv - self-checking bench for gates_sweep_ctrl
// Instance 0 uses SETTLE_CYCLES=1 with a registered gate; instance 1 uses SETTLE_CYCLES=0 with a combinational gate.
module tb_gates_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       st   [2];
    logic       ab   [2];
    logic [7:0] ex   [2];
    logic [7:0] gt   [2];
    logic       z0, z1;
    logic       oa   [2];
    logic       ob   [2];
    logic       oc   [2];
    logic       obusy[2];
    logic       odone[2];
    logic       opass[2];
    logic [7:0] otruth[2];
    logic [3:0] oerr [2];
    logic [2:0] ofirst[2];

    int n_cmp = 0;
    int n_bad = 0;

    gates_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(rst), .start(st[0]), .abort(ab[0]), .expected(ex[0]), .Z(z0),
        .A(oa[0]), .B(ob[0]), .C(oc[0]), .busy(obusy[0]), .done(odone[0]), .truth(otruth[0]),
        .pass(opass[0]), .err_count(oerr[0]), .first_err_idx(ofirst[0])
    );

    gates_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst), .start(st[1]), .abort(ab[1]), .expected(ex[1]), .Z(z1),
        .A(oa[1]), .B(ob[1]), .C(oc[1]), .busy(obusy[1]), .done(odone[1]), .truth(otruth[1]),
        .pass(opass[1]), .err_count(oerr[1]), .first_err_idx(ofirst[1])
    );

    // Gate under test: an arbitrary 3-input function given by its truth table.
    logic [2:0] v0, v1;
    assign v0 = {oa[0], ob[0], oc[0]};
    assign v1 = {oa[1], ob[1], oc[1]};
    always @(posedge clk) z0 <= gt[0][v0];
    assign z1 = gt[1][v1];

    typedef struct {
        int         inst;
        logic [7:0] tbl;
        logic [7:0] expv;
        logic [7:0] et;
        logic       ep;
        logic [3:0] ee;
        logic [2:0] ef;
        int         x1;
        int         x2;
        bit         sid;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int abc(input int inst);
        return int'({oa[inst], ob[inst], oc[inst]});
    endfunction

    task automatic chk_idle_zero(input string tag, input int inst);
        chk({tag, "_abc"},   abc(inst), 0);
        chk({tag, "_busy"},  int'(obusy[inst]), 0);
        chk({tag, "_done"},  int'(odone[inst]), 0);
        chk({tag, "_truth"}, int'(otruth[inst]), 0);
        chk({tag, "_pass"},  int'(opass[inst]), 0);
        chk({tag, "_err"},   int'(oerr[inst]), 0);
        chk({tag, "_first"}, int'(ofirst[inst]), 0);
    endtask

    // Reference: the result depends only on the difference between captured and expected tables.
    function automatic void model(input logic [7:0] t, input logic [7:0] e,
                                  output logic [7:0] mt, output logic mp,
                                  output logic [3:0] me, output logic [2:0] mf);
        logic [7:0] d;
        d  = t ^ e;
        mt = t;
        mp = (d == 8'd0);
        me = 4'd0;
        mf = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (d[k]) begin
                me = me + 4'd1;
                mf = 3'(k);
            end
        end
    endfunction

    task automatic run_sweep(input string tag, input vec_t v);
        int p;
        int last;
        p    = (v.inst == 0) ? 3 : 2;
        last = 8 * p;
        gt[v.inst] = v.tbl;
        ex[v.inst] = v.expv;
        st[v.inst] = 1'b1;
        step();
        chk({tag, "_accept_busy"},  int'(obusy[v.inst]), 1);
        chk({tag, "_accept_truth"}, int'(otruth[v.inst]), 0);
        for (int j = 1; j <= last; j++) begin
            st[v.inst] = (j == v.x1 || j == v.x2);
            ex[v.inst] = 8'($urandom);
            step();
            if (j < last) begin
                chk($sformatf("%s_abc_c%0d", tag, j),  abc(v.inst), (j - 1) / p);
                chk($sformatf("%s_busy_c%0d", tag, j), int'(obusy[v.inst]), 1);
                chk($sformatf("%s_done_c%0d", tag, j), int'(odone[v.inst]), 0);
            end else begin
                chk({tag, "_end_abc"},   abc(v.inst), 0);
                chk({tag, "_end_busy"},  int'(obusy[v.inst]), 0);
                chk({tag, "_end_done"},  int'(odone[v.inst]), 1);
                chk({tag, "_truth"},     int'(otruth[v.inst]), int'(v.et));
                chk({tag, "_pass"},      int'(opass[v.inst]), int'(v.ep));
                chk({tag, "_err"},       int'(oerr[v.inst]), int'(v.ee));
                chk({tag, "_first"},     int'(ofirst[v.inst]), int'(v.ef));
            end
        end
        st[v.inst] = v.sid;
        step();
        st[v.inst] = 1'b0;
        chk({tag, "_post_done"}, int'(odone[v.inst]), 0);
        chk({tag, "_post_busy"}, int'(obusy[v.inst]), 0);
        chk({tag, "_post_pass"}, int'(opass[v.inst]), int'(v.ep));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t       rv;
        logic       seen;
        vecs[0] = '{0, 8'hE8, 8'hE8, 8'hE8, 1'b1, 4'd0, 3'd0, 0, 0,  1'b0};
        vecs[1] = '{0, 8'hE8, 8'hE9, 8'hE8, 1'b0, 4'd1, 3'd0, 0, 0,  1'b0};
        vecs[2] = '{0, 8'hE8, 8'h68, 8'hE8, 1'b0, 4'd1, 3'd7, 0, 0,  1'b1};
        vecs[3] = '{1, 8'h80, 8'h80, 8'h80, 1'b1, 4'd0, 3'd0, 0, 0,  1'b0};
        vecs[4] = '{0, 8'hE8, 8'hE8, 8'hE8, 1'b1, 4'd0, 3'd0, 3, 10, 1'b0};
        vecs[5] = '{1, 8'h80, 8'h0F, 8'h80, 1'b0, 4'd5, 3'd0, 4, 0,  1'b1};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; ex[i] = 8'h00; gt[i] = 8'h00;
        end
        step();
        step();
        chk_idle_zero("reset0", 0);
        chk_idle_zero("reset1", 1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a sweep after some state has accumulated.
        gt[0] = 8'hFF; ex[0] = 8'h00; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        repeat (4) step();
        chk("rstmid_pre_truth", int'(otruth[0]), 1);
        chk("rstmid_pre_err",   int'(oerr[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_zero("rstmid", 0);
        seen = 1'b0;
        repeat (30) begin
            step();
            seen = seen | odone[0] | obusy[0];
        end
        chk("rstmid_no_done", int'(seen), 0);
        run_sweep("after_rst", vecs[0]);

        // Abort mid-sweep, then abort+start together in IDLE.
        gt[0] = 8'hFF; ex[0] = 8'h00; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        repeat (6) step();
        ab[0] = 1'b1;
        step();
        ab[0] = 1'b0;
        chk_idle_zero("abort", 0);
        seen = 1'b0;
        repeat (30) begin
            step();
            seen = seen | odone[0];
        end
        chk("abort_no_done", int'(seen), 0);
        ab[0] = 1'b1; st[0] = 1'b1;
        step();
        ab[0] = 1'b0; st[0] = 1'b0;
        chk("abort_start_busy0", int'(obusy[0]), 0);
        step();
        chk("abort_start_busy1", int'(obusy[0]), 0);

        // Start held high: next sweep is taken on the first IDLE cycle after DONE.
        gt[1] = 8'h80; ex[1] = 8'h80; st[1] = 1'b1;
        step();
        repeat (16) step();
        chk("hold_done",      int'(odone[1]), 1);
        step();
        chk("hold_done_busy", int'(obusy[1]), 0);
        step();
        chk("hold_restart",   int'(obusy[1]), 1);
        st[1] = 1'b0; ab[1] = 1'b1;
        step();
        ab[1] = 1'b0;
        chk("hold_abort_busy",  int'(obusy[1]), 0);
        chk("hold_abort_truth", int'(otruth[1]), 0);

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 16; r++) begin
            rv.inst = int'($urandom_range(1, 0));
            rv.tbl  = 8'($urandom);
            rv.expv = ($urandom_range(2, 0) == 0) ? rv.tbl : 8'($urandom);
            model(rv.tbl, rv.expv, rv.et, rv.ep, rv.ee, rv.ef);
            rv.x1  = int'($urandom_range(16, 1));
            rv.x2  = 0;
            rv.sid = 1'($urandom);
            run_sweep($sformatf("rand%0d", r), rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
